// File: rtl/kuznechik_dec_iter.sv
// kuznechik_dec_iter: iterative Kuznechik (GOST R 34.12-2015) block decryptor.
// It has its own key-schedule FSM. The ten round keys are expanded once per
// key and kept for every later block. UNROLL inverse rounds run per cycle.
//
// Ports:
//   clk, rst               clock (rising edge), asynchronous active-high reset
//   key_valid/key_ready    256-bit master key handshake (key[255:128] = K1)
//   in_valid/in_ready      128-bit ciphertext handshake (encoded)
//   out_valid/out_ready    128-bit plaintext handshake (block)
//   busy                   high while expanding, decrypting or holding output
module kuznechik_dec_iter #(
    parameter int UNROLL    = 1,
    parameter int KEY_STEPS = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         key_valid,
    output logic         key_ready,
    input  logic [255:0] key,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] encoded,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] block,
    output logic         busy
);
    if (UNROLL != 1 && UNROLL != 3 && UNROLL != 9) begin : g_bad_unroll
        $error("kuznechik_dec_iter: UNROLL must be 1, 3 or 9");
    end
    if (KEY_STEPS != 1 && KEY_STEPS != 2 && KEY_STEPS != 4 && KEY_STEPS != 8) begin : g_bad_ksteps
        $error("kuznechik_dec_iter: KEY_STEPS must be 1, 2, 4 or 8");
    end

    localparam int NRCYC = 9 / UNROLL;

    // Substitution pi; entry 0 occupies the most significant byte.
    localparam logic [2047:0] PI = {
        128'hFCEEDD11CF6E3116FBC4FADA23C5044D, 128'hE977F0DB932E99BA1736F1BB14CD5FC1,
        128'hF918655AE25CEF21811C3C428B018E4F, 128'h058402AEE36A8FA0060BED987FD4D31F,
        128'hEB342C51EAC848ABF22A68A2FD3ACECC, 128'hB5700E56080C7612BF7213479CB75D87,
        128'h15A19629107B9AC7F391786F9D9EB2B1, 128'h3275193DFF358A7E6D54C680C3BD0D57,
        128'hDFF524A93EA843C9D779D6F67C22B903, 128'hE00FECDE7A94B0BCDCE828504E330A4A,
        128'hA79760731E0062441AB83882649F2641, 128'hAD454692275E552F8CA3A57D69D5953B,
        128'h0758B34086AC1DF730376BE488D9E789, 128'hE11B83494C3FF8FE8D53AA90CAD88561,
        128'h207167A42D2B095BCB9B25D0BEE56C52, 128'h59A674D2E6F4B4C0D166AFC2394B63B6};

    // Linear-map coefficients aligned with the byte they multiply (a15 on top).
    localparam logic [127:0] LCOEF = 128'h94208510C2C001FB01C0C21085209401;

    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p;
        logic [7:0] t;
        p = '0;
        t = x;
        for (int b = 0; b < 8; b++) begin
            if (y[b]) p = p ^ t;
            // x^8 reduces to x^7+x^6+x+1 (0xC3).
            t = t[7] ? ({t[6:0], 1'b0} ^ 8'hC3) : {t[6:0], 1'b0};
        end
        return p;
    endfunction

    function automatic logic [7:0] lin(input logic [127:0] x);
        logic [7:0] acc;
        acc = '0;
        for (int j = 0; j < 16; j++) acc = acc ^ gf_mul(x[8*j +: 8], LCOEF[8*j +: 8]);
        return acc;
    endfunction

    function automatic logic [127:0] l_fwd(input logic [127:0] x);
        logic [127:0] r;
        r = x;
        for (int n = 0; n < 16; n++) r = {lin(r), r[127:8]};
        return r;
    endfunction

    // Inverse R: shift one byte left, new low byte = l(a14..a0, a15).
    function automatic logic [127:0] l_inv(input logic [127:0] x);
        logic [127:0] r;
        r = x;
        for (int n = 0; n < 16; n++) r = {r[119:0], lin({r[119:0], r[127:120]})};
        return r;
    endfunction

    function automatic logic [2047:0] build_inv();
        logic [2047:0] t;
        int v;
        t = '0;
        for (int i = 0; i < 256; i++) begin
            v = int'(PI[2047 - 8*i -: 8]);
            t[2047 - 8*v -: 8] = 8'(i);
        end
        return t;
    endfunction

    localparam logic [2047:0] PI_INV = build_inv();

    function automatic logic [127:0] s_fwd(input logic [127:0] x);
        logic [127:0] r;
        int v;
        r = '0;
        for (int j = 0; j < 16; j++) begin
            v = int'(x[8*j +: 8]);
            r[8*j +: 8] = PI[2047 - 8*v -: 8];
        end
        return r;
    endfunction

    function automatic logic [127:0] s_inv(input logic [127:0] x);
        logic [127:0] r;
        int v;
        r = '0;
        for (int j = 0; j < 16; j++) begin
            v = int'(x[8*j +: 8]);
            r[8*j +: 8] = PI_INV[2047 - 8*v -: 8];
        end
        return r;
    endfunction

    // Iteration constants: C_i = L(i) lives at slice i-1.
    function automatic logic [4095:0] build_c();
        logic [4095:0] t;
        t = '0;
        for (int i = 1; i <= 32; i++) t[128*(i-1) +: 128] = l_fwd(128'(i));
        return t;
    endfunction

    localparam logic [4095:0] CTBL = build_c();

    typedef enum logic [2:0] {NOKEY, EXPAND, READY, ROUND, DONE} state_t;

    state_t       state_q;
    logic         key_ready_q, in_ready_q, out_valid_q, busy_q, cache_vld_q;
    logic [5:0]   kcnt_q;
    logic [3:0]   rcnt_q;
    logic [127:0] block_q;
    logic [127:0] a_q, a_d;
    logic [127:0] ka1_q, ka0_q, ka1_d, ka0_d, kf;
    logic [127:0] rk_q [1:10];
    logic         key_hs, in_hs, kstore;
    logic [3:0]   kslot;
    int           ci, ki;

    // A pending block takes priority: key_ready drops while a block is offered.
    assign in_ready  = in_ready_q & cache_vld_q;
    assign in_hs     = in_valid & in_ready;
    assign key_ready = key_ready_q & ~in_hs;
    assign key_hs    = key_valid & key_ready;
    assign out_valid = out_valid_q;
    assign block     = block_q;
    assign busy      = busy_q;

    // Key schedule: KEY_STEPS Feistel iterations from the current pair.
    always_comb begin
        ka1_d = ka1_q;
        ka0_d = ka0_q;
        kf    = '0;
        ci    = 0;
        for (int s = 0; s < KEY_STEPS; s++) begin
            ci    = (int'(kcnt_q) + s) % 32;
            kf    = l_fwd(s_fwd(ka1_d ^ CTBL[128*ci +: 128])) ^ ka0_d;
            ka0_d = ka1_d;
            ka1_d = kf;
        end
        // Every 8th iteration ends on a cycle boundary because KEY_STEPS divides 8.
        kstore = ((int'(kcnt_q) + KEY_STEPS) % 8) == 0;
        kslot  = 4'((int'(kcnt_q) + KEY_STEPS) / 8 * 2 + 1);
    end

    // Decrypt datapath: UNROLL inverse rounds with keys K9 down to K1.
    always_comb begin
        a_d = a_q;
        ki  = 1;
        for (int u = 0; u < UNROLL; u++) begin
            ki  = 9 - int'(rcnt_q) * UNROLL - u;
            if (ki < 1) ki = 1;
            a_d = s_inv(l_inv(a_d)) ^ rk_q[4'(ki)];
        end
    end

    always_ff @(posedge clk) begin
        if (key_hs) begin
            ka1_q    <= key[255:128];
            ka0_q    <= key[127:0];
            rk_q[1]  <= key[255:128];
            rk_q[2]  <= key[127:0];
        end else if (state_q == EXPAND && kcnt_q != 6'd32) begin
            ka1_q <= ka1_d;
            ka0_q <= ka0_d;
            if (kstore) begin
                rk_q[kslot]        <= ka1_d;
                rk_q[kslot + 4'd1] <= ka0_d;
            end
        end
        if (in_hs) begin
            a_q <= encoded ^ rk_q[10];
        end else if (state_q == ROUND && rcnt_q != 4'(NRCYC)) begin
            a_q <= a_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= NOKEY;
            key_ready_q <= 1'b1;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            cache_vld_q <= 1'b0;
            kcnt_q      <= '0;
            rcnt_q      <= '0;
            block_q     <= '0;
        end else begin
            case (state_q)
                NOKEY: begin
                    if (key_hs) begin
                        state_q     <= EXPAND;
                        key_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        kcnt_q      <= '0;
                    end
                end
                EXPAND: begin
                    // One extra cycle after the last iteration to publish the cache.
                    if (kcnt_q == 6'd32) begin
                        state_q     <= READY;
                        key_ready_q <= 1'b1;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        cache_vld_q <= 1'b1;
                    end else begin
                        kcnt_q <= kcnt_q + 6'(KEY_STEPS);
                    end
                end
                READY: begin
                    if (in_hs) begin
                        state_q     <= ROUND;
                        key_ready_q <= 1'b0;
                        in_ready_q  <= 1'b0;
                        busy_q      <= 1'b1;
                        rcnt_q      <= '0;
                    end else if (key_hs) begin
                        state_q     <= EXPAND;
                        key_ready_q <= 1'b0;
                        in_ready_q  <= 1'b0;
                        busy_q      <= 1'b1;
                        cache_vld_q <= 1'b0;
                        kcnt_q      <= '0;
                    end
                end
                ROUND: begin
                    // Counter saturates at NRCYC; that cycle moves the result out.
                    if (rcnt_q == 4'(NRCYC)) begin
                        state_q     <= DONE;
                        block_q     <= a_q;
                        out_valid_q <= 1'b1;
                    end else begin
                        rcnt_q <= rcnt_q + 4'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= READY;
                        out_valid_q <= 1'b0;
                        key_ready_q <= 1'b1;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: state_q <= NOKEY;
            endcase
        end
    end
endmodule

// File: tb/tb_kuznechik_dec_iter.sv
// tb_kuznechik_dec_iter: directed bench for kuznechik_dec_iter using the GOST
// test vector. Three instances: (UNROLL,KEY_STEPS) = (1,1), (3,8), (9,8).
module tb_kuznechik_dec_iter;
    localparam logic [255:0] KEY = 256'h8899aabbccddeeff0011223344556677fedcba98765432100123456789abcdef;
    localparam logic [127:0] CT  = 128'h7f679d90bebc24305a468d42b9d4edcd;
    localparam logic [127:0] PT  = 128'h1122334455667700ffeeddccbbaa9988;
    localparam logic [127:0] K3  = 128'hdb31485315694343228d6aef8cc78c44;

    logic         clk = 1'b0;
    logic         rst;
    logic         kv [3];
    logic [255:0] kk [3];
    logic         iv [3];
    logic [127:0] enc [3];
    logic         ordy [3];
    wire          kr [3];
    wire          ir [3];
    wire          ov [3];
    wire  [127:0] blk [3];
    wire          bsy [3];

    int checks = 0;
    int errors = 0;
    int n;
    logic seen;

    always #5 clk = ~clk;

    kuznechik_dec_iter #(.UNROLL(1), .KEY_STEPS(1)) u0 (
        .clk(clk), .rst(rst), .key_valid(kv[0]), .key_ready(kr[0]), .key(kk[0]),
        .in_valid(iv[0]), .in_ready(ir[0]), .encoded(enc[0]), .out_valid(ov[0]),
        .out_ready(ordy[0]), .block(blk[0]), .busy(bsy[0]));
    kuznechik_dec_iter #(.UNROLL(3), .KEY_STEPS(8)) u1 (
        .clk(clk), .rst(rst), .key_valid(kv[1]), .key_ready(kr[1]), .key(kk[1]),
        .in_valid(iv[1]), .in_ready(ir[1]), .encoded(enc[1]), .out_valid(ov[1]),
        .out_ready(ordy[1]), .block(blk[1]), .busy(bsy[1]));
    kuznechik_dec_iter #(.UNROLL(9), .KEY_STEPS(8)) u2 (
        .clk(clk), .rst(rst), .key_valid(kv[2]), .key_ready(kr[2]), .key(kk[2]),
        .in_valid(iv[2]), .in_ready(ir[2]), .encoded(enc[2]), .out_valid(ov[2]),
        .out_ready(ordy[2]), .block(blk[2]), .busy(bsy[2]));

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Key handshake on instance d, then count cycles until in_ready rises.
    task automatic load_key(input int d, input logic [255:0] k, output int cyc);
        kk[d] = k;
        kv[d] = 1'b1;
        #1;
        check("key_ready_before_key", 128'(kr[d]), 128'd1);
        tick();
        kv[d] = 1'b0;
        check("busy_in_expand", 128'(bsy[d]), 128'd1);
        cyc = 0;
        while (ir[d] !== 1'b1 && cyc < 200) begin
            tick();
            cyc++;
        end
    endtask

    // Block handshake on instance d, then count cycles until out_valid rises.
    task automatic run_block(input int d, output int cyc);
        enc[d] = CT;
        iv[d]  = 1'b1;
        #1;
        check("in_ready_before_block", 128'(ir[d]), 128'd1);
        tick();
        iv[d] = 1'b0;
        cyc = 0;
        while (ov[d] !== 1'b1 && cyc < 200) begin
            tick();
            cyc++;
        end
    endtask

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 3; d++) begin
            kv[d] = 1'b0; kk[d] = '0; iv[d] = 1'b0; enc[d] = '0; ordy[d] = 1'b0;
        end
        tick();
        tick();
        check("rst_key_ready", 128'(kr[0]), 128'd1);
        check("rst_in_ready", 128'(ir[0]), 128'd0);
        check("rst_out_valid", 128'(ov[0]), 128'd0);
        check("rst_block", blk[0], 128'd0);
        check("rst_busy", 128'(bsy[0]), 128'd0);
        rst = 1'b0;
        tick();

        // Expansion and first decrypt, UNROLL=1 KEY_STEPS=1.
        load_key(0, KEY, n);
        check("u0_key_to_in_ready", 128'(n), 128'd33);
        check("u0_K3", u0.rk_q[3], K3);
        check("u0_key_ready_in_ready_state", 128'(kr[0]), 128'd1);
        run_block(0, n);
        check("u0_latency", 128'(n), 128'd10);
        check("u0_block", blk[0], PT);

        // Backpressure: out_ready low for 7 cycles.
        seen = 1'b0;
        for (int c = 0; c < 7; c++) begin
            if (ov[0] !== 1'b1 || blk[0] !== PT || ir[0] !== 1'b0 || kr[0] !== 1'b0) seen = 1'b1;
            tick();
        end
        check("bp_hold_stable", 128'(seen), 128'd0);
        check("bp_out_valid_held", 128'(ov[0]), 128'd1);
        ordy[0] = 1'b1;
        tick();
        check("bp_in_ready_after_drain", 128'(ir[0]), 128'd1);
        check("bp_out_valid_dropped", 128'(ov[0]), 128'd0);

        // Key cache: three blocks back to back, no re-expansion.
        for (int b = 0; b < 3; b++) begin
            run_block(0, n);
            check("cache_latency", 128'(n), 128'd10);
            check("cache_block", blk[0], PT);
            tick();
            check("cache_in_ready_next", 128'(ir[0]), 128'd1);
        end
        ordy[0] = 1'b0;

        // Contention: key and block together, block wins, key waits.
        kk[0]  = '0;
        kv[0]  = 1'b1;
        enc[0] = CT;
        iv[0]  = 1'b1;
        #1;
        check("cont_key_ready_low", 128'(kr[0]), 128'd0);
        check("cont_in_ready_high", 128'(ir[0]), 128'd1);
        tick();
        iv[0] = 1'b0;
        n = 0;
        while (ov[0] !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check("cont_block_latency", 128'(n), 128'd10);
        check("cont_block_old_key", blk[0], PT);
        ordy[0] = 1'b1;
        tick();
        ordy[0] = 1'b0;
        check("cont_key_ready_after_drain", 128'(kr[0]), 128'd1);
        tick();
        kv[0] = 1'b0;
        check("cont_key_taken_busy", 128'(bsy[0]), 128'd1);
        check("cont_key_taken_in_ready", 128'(ir[0]), 128'd0);
        n = 0;
        while (ir[0] !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check("key0_to_in_ready", 128'(n), 128'd33);
        run_block(0, n);
        check("key0_latency", 128'(n), 128'd10);
        checks++;
        assert (blk[0] !== PT) else begin
            errors++;
            $error("FAIL key0_differs: observed %0h expected a value other than %0h", blk[0], PT);
        end

        // Unroll sweep.
        load_key(1, KEY, n);
        check("u1_key_to_in_ready", 128'(n), 128'd5);
        run_block(1, n);
        check("u1_latency", 128'(n), 128'd4);
        check("u1_block", blk[1], PT);
        load_key(2, KEY, n);
        check("u2_key_to_in_ready", 128'(n), 128'd5);
        run_block(2, n);
        check("u2_latency", 128'(n), 128'd2);
        check("u2_block", blk[2], PT);

        // Reset in the third ROUND cycle aborts the block.
        ordy[0] = 1'b1;
        tick();
        ordy[0] = 1'b0;
        enc[0] = CT;
        iv[0]  = 1'b1;
        tick();
        iv[0] = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("arst_key_ready", 128'(kr[0]), 128'd1);
        check("arst_in_ready", 128'(ir[0]), 128'd0);
        check("arst_block", blk[0], 128'd0);
        check("arst_busy", 128'(bsy[0]), 128'd0);
        tick();
        rst = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 15; c++) begin
            if (ov[0] !== 1'b0) seen = 1'b1;
            tick();
        end
        check("arst_no_out_valid", 128'(seen), 128'd0);
        check("arst_nokey_key_ready", 128'(kr[0]), 128'd1);
        check("arst_nokey_in_ready", 128'(ir[0]), 128'd0);
        check("arst_nokey_block", blk[0], 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
